// File: rtl/move_pkg.sv
// Shared constants for the move_ctrl block: direction indices, default raster
// size, debounce counter width and the opposing-pair cancel helper.
package move_pkg;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;
  localparam int DIR_NUM   = 4;

  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;

  localparam int DB_CNT_W  = 24;

  // Returns {a_wins, b_wins}: a pair pressed together means neither moves.
  function automatic logic [1:0] cancel_pair(input logic a, input logic b);
    return {a & ~b, b & ~a};
  endfunction

endpackage

// File: rtl/move_ctrl_debounce.sv
// Per-button conditioner: 2-flop synchronizer followed by a hold-time
// debouncer that publishes the accepted (stable) level.
module debounce
  import move_pkg::*;
#(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_state
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);
  localparam logic [DB_CNT_W-1:0] DB_ONE  = DB_CNT_W'(1);
  localparam logic [DB_CNT_W-1:0] DB_ZERO = DB_CNT_W'(0);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_state;
  logic [DB_CNT_W-1:0] r_cnt;

  // Synchronize the raw level, then require DB_CYCLES disagreeing cycles in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= DB_ZERO;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_state) begin
        if (r_cnt == DB_LAST) begin
          r_state <= r_sync2;
          r_cnt   <= DB_ZERO;
        end else begin
          r_cnt   <= r_cnt + DB_ONE;
        end
      end else begin
        r_cnt <= DB_ZERO;
      end
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/move_ctrl.sv
// Debounced four-way move controller, latched once per frame end.
// Optional MOVE_CTRL_SPEED_DIV_EN adds speed_sel to divide the frame strobe.
module move_ctrl
  import move_pkg::*;
#(
  parameter int pA        = 10,
  parameter int H_ACT     = H_ACT_DEF,
  parameter int V_ACT     = V_ACT_DEF,
  parameter int DB_CYCLES = 250000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [pA-1:0] pix_x,
  input  logic [pA-1:0] pix_y,
  input  logic          pix_v,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
`ifdef MOVE_CTRL_SPEED_DIV_EN
  input  logic [1:0]    speed_sel,
`endif
  output logic          up,
  output logic          down,
  output logic          left,
  output logic          right,
  output logic          imgReturn
);

  localparam logic [pA-1:0] X_LAST = pA'(H_ACT - 1);
  localparam logic [pA-1:0] Y_LAST = pA'(V_ACT - 1);

  logic [DIR_NUM-1:0] w_btn_raw;
  logic [DIR_NUM-1:0] w_acc;
  logic [1:0]         w_ud;
  logic [1:0]         w_lr;
  logic               w_fe;
  logic               w_fire;
  logic               w_div_hit;

  logic r_fe_prev;
  logic r_img;
  logic r_up;
  logic r_down;
  logic r_left;
  logic r_right;

  assign w_btn_raw[DIR_UP]    = btn_up;
  assign w_btn_raw[DIR_DOWN]  = btn_down;
  assign w_btn_raw[DIR_LEFT]  = btn_left;
  assign w_btn_raw[DIR_RIGHT] = btn_right;

  for (genvar g = 0; g < DIR_NUM; g++) begin : g_db
    debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (w_btn_raw[g]),
      .o_state(w_acc[g])
    );
  end

  // A stalled pixel counter holds the match high; only its first cycle counts.
  assign w_fe   = pix_v && (pix_x == X_LAST) && (pix_y == Y_LAST);
  assign w_fire = w_fe && !r_fe_prev;

  assign w_ud = cancel_pair(w_acc[DIR_UP],   w_acc[DIR_DOWN]);
  assign w_lr = cancel_pair(w_acc[DIR_LEFT], w_acc[DIR_RIGHT]);

`ifdef MOVE_CTRL_SPEED_DIV_EN
  logic [1:0] r_div;

  // A count already beyond a lowered speed_sel also wraps on the next frame end.
  assign w_div_hit = (r_div >= speed_sel);

  // Frame-end divider, advanced only on accepted frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= 2'd0;
    end else if (w_fire) begin
      r_div <= w_div_hit ? 2'd0 : r_div + 2'd1;
    end else begin
      r_div <= r_div;
    end
  end
`else
  assign w_div_hit = 1'b1;
`endif

  // Strobe and direction latch; the debouncers update on the same edge, so the
  // latch sees the pre-acceptance state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fe_prev <= 1'b0;
      r_img     <= 1'b0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
      r_left    <= 1'b1;
      r_right   <= 1'b1;
    end else begin
      r_fe_prev <= w_fe;
      r_img     <= w_fire && w_div_hit;
      if (w_fire && w_div_hit) begin
        r_up    <= w_ud[1];
        r_down  <= w_ud[0];
        r_left  <= ~w_lr[1];
        r_right <= ~w_lr[0];
      end
    end
  end

  assign up        = r_up;
  assign down      = r_down;
  assign left      = r_left;
  assign right     = r_right;
  assign imgReturn = r_img;

endmodule

// File: tb/tb_move_ctrl.sv
// Directed bench for move_ctrl: vector table of button patterns plus
// hand-timed sequences for glitch, coincidence, reset and stall corners.
module tb_move_ctrl;

  localparam int PA = 10;

  logic          clk;
  logic          rst;
  logic [PA-1:0] pix_x;
  logic [PA-1:0] pix_y;
  logic          pix_v;
  logic          btn_up, btn_down, btn_left, btn_right;
  logic          up, down, left, right, imgReturn;
`ifdef MOVE_CTRL_SPEED_DIV_EN
  logic [1:0]    speed_sel;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  typedef struct {
    logic [3:0] btn;  // {up, down, left, right}
    logic [3:0] exp;  // {up, down, left, right}
  } vec_t;

  vec_t tbl[12];

  move_ctrl #(
    .pA(PA), .H_ACT(8), .V_ACT(4), .DB_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_x(pix_x), .pix_y(pix_y), .pix_v(pix_v),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
`ifdef MOVE_CTRL_SPEED_DIV_EN
    .speed_sel(speed_sel),
`endif
    .up(up), .down(down), .left(left), .right(right), .imgReturn(imgReturn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (imgReturn) pulses <= pulses + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
  endtask

  // Presents a single frame-end pixel; on return the strobe cycle is visible.
  task automatic frame_end_only();
    pix_x = PA'(7); pix_y = PA'(3); pix_v = 1'b1;
    tick();
    pix_x = '0; pix_y = '0; pix_v = 1'b0;
  endtask

  // Two blanking cycles then a full 8x4 raster; returns in the strobe cycle.
  task automatic run_frame();
    pix_v = 1'b0;
    tick();
    tick();
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        pix_x = PA'(x); pix_y = PA'(y); pix_v = 1'b1;
        tick();
      end
    end
    pix_x = '0; pix_y = '0; pix_v = 1'b0;
  endtask

  function automatic logic [3:0] outs();
    return {up, down, left, right};
  endfunction

  initial begin
    int p0;
    tbl[0]  = '{4'b0000, 4'b0011};
    tbl[1]  = '{4'b1000, 4'b1011};
    tbl[2]  = '{4'b0100, 4'b0111};
    tbl[3]  = '{4'b1100, 4'b0011};
    tbl[4]  = '{4'b0010, 4'b0001};
    tbl[5]  = '{4'b0001, 4'b0010};
    tbl[6]  = '{4'b0011, 4'b0011};
    tbl[7]  = '{4'b0010, 4'b0001};
    tbl[8]  = '{4'b1010, 4'b1001};
    tbl[9]  = '{4'b0101, 4'b0110};
    tbl[10] = '{4'b1111, 4'b0011};
    tbl[11] = '{4'b0000, 4'b0011};

    rst = 1'b1;
    pix_x = '0; pix_y = '0; pix_v = 1'b0;
    set_btn(4'b0000);
`ifdef MOVE_CTRL_SPEED_DIV_EN
    speed_sel = 2'd0;
`endif
    tick(); tick(); tick();
    chk("reset_img", imgReturn, 1'b0);
    chk("reset_outs", outs(), 4'b0011);
    rst = 1'b0;

    // Idle frames: one strobe each, released outputs.
    for (int f = 0; f < 3; f++) begin
      run_frame();
      chk("idle_strobe", imgReturn, 1'b1);
      chk("idle_outs", outs(), 4'b0011);
      tick();
      chk("idle_strobe_end", imgReturn, 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      set_btn(tbl[i].btn);
      run_frame();
      chk("vec_strobe", imgReturn, 1'b1);
      chk($sformatf("vec%0d_outs", i), outs(), tbl[i].exp);
      tick();
      chk("vec_strobe_end", imgReturn, 1'b0);
    end

    // Three-cycle glitch falls short of the hold time.
    btn_up = 1'b1;
    tick(); tick(); tick();
    btn_up = 1'b0;
    run_frame();
    chk("glitch_outs", outs(), 4'b0011);
    tick();

    // Acceptance lands on the frame-end edge: old state latched, new one next frame.
    for (int i = 0; i < 8; i++) tick();
    btn_up = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    frame_end_only();
    chk("coinc_strobe", imgReturn, 1'b1);
    chk("coinc_outs_old", outs(), 4'b0011);
    tick();
    run_frame();
    chk("coinc_outs_new", outs(), 4'b1011);

    // Reset asserted in the strobe cycle.
    rst = 1'b1;
    tick();
    chk("rst_strobe_img", imgReturn, 1'b0);
    chk("rst_strobe_outs", outs(), 4'b0011);
    rst = 1'b0;
    btn_up = 1'b0;

    // Reset during the frame-end cycle suppresses that strobe.
    rst = 1'b1;
    frame_end_only();
    rst = 1'b0;
    chk("rst_fe_img", imgReturn, 1'b0);
    tick();
    chk("rst_fe_img2", imgReturn, 1'b0);
    run_frame();
    chk("first_after_rst", imgReturn, 1'b1);
    chk("first_after_rst_outs", outs(), 4'b0011);
    tick();

    // Stalled pixel counter: one pulse, re-armed after a non-matching cycle.
    p0 = pulses;
    pix_x = PA'(7); pix_y = PA'(3); pix_v = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pix_v = 1'b0;
    tick(); tick();
    chk("stall_pulses", pulses - p0, 1);
    frame_end_only();
    tick(); tick();
    chk("rearm_pulses", pulses - p0, 2);

`ifdef MOVE_CTRL_SPEED_DIV_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    speed_sel = 2'd2;
    for (int f = 1; f <= 9; f++) begin
      run_frame();
      chk($sformatf("div2_frame%0d", f), imgReturn, (f % 3) == 0);
      tick();
    end
    speed_sel = 2'd0;
    for (int f = 0; f < 2; f++) begin
      run_frame();
      chk("div0_frame", imgReturn, 1'b1);
      tick();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
